// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared byte width and scheduler state type for the UART
//                transmit arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Circular byte FIFO with registered empty/full flags and a
//                sticky overflow flag for pushes that arrive while full.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [UART_BYTE_W-1:0] push_data,
    input  logic                   pop,
    output logic [UART_BYTE_W-1:0] pop_data,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [UART_BYTE_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic                   r_empty;
    logic                   r_full;
    logic                   r_overflow;

    logic                   w_do_push;
    logic                   w_do_pop;
    logic [c_CNT_W-1:0]     w_count_next;

    // A push is judged against the full flag before any same-cycle pop.
    assign w_do_push    = push && !r_full;
    assign w_do_pop     = pop && !r_empty;
    assign w_count_next = r_count + {{(c_CNT_W-1){1'b0}}, w_do_push}
                                  - {{(c_CNT_W-1){1'b0}}, w_do_pop};

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == c_CNT_W'(DEPTH));
            if (push && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign empty    = r_empty;
    assign full     = r_full;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin sharing of one UartTx between two byte producers,
//                each buffered by a private byte FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req0_start,
    input  logic [UART_BYTE_W-1:0] req0_data,
    output logic                   req0_full,
    output logic                   req0_overflow,
    input  logic                   req1_start,
    input  logic [UART_BYTE_W-1:0] req1_data,
    output logic                   req1_full,
    output logic                   req1_overflow,
    output logic                   tx_start,
    output logic [UART_BYTE_W-1:0] sdata,
    input  logic                   tx_busy
);

    sched_state_t           r_state;
    logic                   r_last_grant;
    logic                   r_tx_start;
    logic [UART_BYTE_W-1:0] r_sdata;

    logic                   w_empty0;
    logic                   w_empty1;
    logic [UART_BYTE_W-1:0] w_head0;
    logic [UART_BYTE_W-1:0] w_head1;
    logic                   w_any;
    logic                   w_grant;
    logic                   w_pop0;
    logic                   w_pop1;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clock     (clock),
        .reset     (reset),
        .push      (req0_start),
        .push_data (req0_data),
        .pop       (w_pop0),
        .pop_data  (w_head0),
        .empty     (w_empty0),
        .full      (req0_full),
        .overflow  (req0_overflow)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clock     (clock),
        .reset     (reset),
        .push      (req1_start),
        .push_data (req1_data),
        .pop       (w_pop1),
        .pop_data  (w_head1),
        .empty     (w_empty1),
        .full      (req1_full),
        .overflow  (req1_overflow)
    );

    // Under contention the requester not served last wins; otherwise the
    // only non-empty FIFO is taken.
    always_comb begin
        w_any   = !w_empty0 || !w_empty1;
        w_grant = (!w_empty0 && !w_empty1) ? ~r_last_grant : w_empty0;
        w_pop0  = (r_state == IDLE) && w_any && !w_grant;
        w_pop1  = (r_state == IDLE) && w_any && w_grant;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_tx_start   <= 1'b0;
            r_sdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sdata      <= w_grant ? w_head1 : w_head0;
                        r_last_grant <= w_grant;
                        r_tx_start   <= 1'b1;
                        r_state      <= START;
                    end
                end
                START: begin
                    r_tx_start <= 1'b0;
                    r_state    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign tx_start = r_tx_start;
    assign sdata    = r_sdata;

endmodule
`default_nettype wire
